game_state_ctrl: RTL and testbench
==================================

# game_state_ctrl

Top-level screen sequencer for the Undertale-style game. It generates the 4-bit `status` code that the title, battle, game-over and win sprite/ROM stages decode to decide what they draw. It also produces a blink enable for the title text, a fade level for the colour mapper, and a one-cycle battle-start pulse. It runs on the system clock, takes keyboard codes and battle outcome flags as inputs, and derives frame timing from the VGA frame clock.

## Interface
Parameters:
- BLINK_FRAMES, 30: frame ticks between toggles of `title_visible` while on the title screen.
- GAMEOVER_FRAMES, 120: frame ticks the game-over screen ignores input.
- ENTER_CODE, 8'h28: HID keycode for Enter.
- CONFIRM_CODE, 8'h1D: HID keycode for Z.

Ports:
- Clk, input, 1: system clock (50 MHz).
- Reset, input, 1: asynchronous, active-high reset.
- frame_clk, input, 1: VGA vsync-derived frame clock, asynchronous to Clk.
- keycode, input, 8: current HID keycode, synchronous to Clk; 0 means no key.
- player_dead, input, 1: level flag from the battle logic.
- battle_won, input, 1: level flag from the battle logic.
- status, output, 4: screen code. 1 = TITLE, 2 = FADE, 3 = BATTLE, 4 = GAMEOVER, 5 = WIN.
- title_visible, output, 1: title text enable. The title stage ANDs it with its hit flag.
- fade_level, output, 4: dimming amount for the colour mapper. 0 = full brightness, 15 = darkest.
- battle_start, output, 1: one-Clk pulse on entry to BATTLE.

## Operation
**Frame tick**
- `frame_clk` passes through a 2-flop synchroniser, then a third flop.
- `tick` = sync2 & ~sync3. This gives exactly one Clk pulse per rising edge of `frame_clk`.

**Confirm edge**
- `hit` = (keycode == ENTER_CODE) || (keycode == CONFIRM_CODE).
- `hit_prev` is registered every cycle.
- `confirm` = hit & ~hit_prev.
- Holding a key produces one `confirm`. Switching directly from Enter to Z produces none.

**8-bit `frame_cnt`**
- Clears on every state change.
- Increments on `tick` in FADE and GAMEOVER.
- Saturates at 255.

**State machine** (registered; `status` is the state encoding):
- TITLE:
  - `tick` increments a blink counter. When the count reaches BLINK_FRAMES-1 and another `tick` arrives, `title_visible` toggles and the blink counter clears.
  - `confirm` moves to FADE.
- FADE:
  - `fade_level` = frame_cnt[4:1].
  - When `tick` arrives with frame_cnt == 31, move to BATTLE and assert `battle_start` for that one cycle.
  - Keys and battle flags are ignored.
- BATTLE:
  - `player_dead` moves to GAMEOVER.
  - Otherwise `battle_won` moves to WIN.
  - If both are asserted in the same cycle, `player_dead` wins.
  - `fade_level` is 0.
- GAMEOVER:
  - `confirm` moves to TITLE only when frame_cnt >= GAMEOVER_FRAMES.
  - Earlier presses are discarded; they are not queued.
- WIN:
  - `confirm` moves to TITLE.
- Encodings 0 and 6–15 are illegal and fall back to TITLE on the next cycle.

**On entry to TITLE** (from any state):
- `title_visible` = 1.
- Blink counter = 0.
- `fade_level` = 0.

**`title_visible` outside TITLE:** held at 1.

## Timing
**Reset values** (asynchronous, take effect immediately on Reset):
- status = 1, title_visible = 1, fade_level = 0, battle_start = 0.
- frame_cnt = 0, blink counter = 0, synchroniser flops = 0, hit_prev = 0.

**Reset mid-operation:** returns to TITLE from any state with no residual pulse.

**Latencies:**
- frame_clk rise to `tick`: 3 Clk (worst case 4).
- State change: registered, so `status` updates on the Clk edge after the qualifying `confirm`, `tick` or flag.
- `confirm`: asserted in the cycle keycode first matches, so `status` changes one Clk after keycode changes.

**`battle_start`:**
- Asserted coincident with the first cycle of status == 3.
- Width is exactly 1 Clk.

**Fade duration:** exactly 32 frame ticks. `fade_level` steps 0,0,1,1,…,15,15.

**Simultaneous events:**
- A `confirm` in the same cycle as a `tick` in TITLE: the state change wins and the blink toggle is dropped.
- A `tick` on the transition cycle does not increment frame_cnt in the new state.

**Combinational paths:** outputs are glitch-free registers. There is no combinational path from inputs to outputs.

## Test plan
- **Reset and blink:** assert Reset mid-BATTLE, then run 65 frame ticks. Required: status returns to 1 immediately, and `title_visible` toggles after tick 30 and tick 60.
- **Start and fade:** hold keycode = 8'h28 for 10 frames. Required:
  - exactly one transition to status 2;
  - `fade_level` reaches 15 at frame_cnt 30;
  - after the 32nd tick, status = 3 with a single-cycle `battle_start`.
- **Key edge rules:** switch keycode 8'h28 → 8'h1D with no release. Required: no extra `confirm`. Releasing to 0 and pressing again produces one `confirm`.
- **Battle outcome priority:** in BATTLE, raise `player_dead` and `battle_won` in the same cycle. Required: status = 4 next cycle.
- **Game-over lockout:** press Z at frame 50. Required: stays at 4. A press at frame 121 returns to status 1 with `title_visible` = 1.
- **Win path and illegal state:** in BATTLE, `battle_won` → status 5, then Z returns to 1. Force the state register to 4'd9. Required: status = 1 on the next cycle.

Source files
------------

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: top-level screen sequencer. Produces the screen status code,
// the title blink enable, the fade level for the colour mapper and a one-cycle
// battle-start pulse. Frame timing is taken from the asynchronous VGA frame
// clock through a synchroniser; all outputs come straight from registers.
module game_state_ctrl #(
    parameter int          BLINK_FRAMES    = 30,
    parameter int          GAMEOVER_FRAMES = 120,
    parameter logic [7:0]  ENTER_CODE      = 8'h28,
    parameter logic [7:0]  CONFIRM_CODE    = 8'h1D
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       player_dead,
    input  logic       battle_won,
    output logic [3:0] status,
    output logic       title_visible,
    output logic [3:0] fade_level,
    output logic       battle_start
);

    // Screen codes double as the status output encoding.
    typedef enum logic [3:0] {
        ST_TITLE    = 4'd1,
        ST_FADE     = 4'd2,
        ST_BATTLE   = 4'd3,
        ST_GAMEOVER = 4'd4,
        ST_WIN      = 4'd5
    } state_t;

    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // State is held as a plain vector so that encodings outside the enum can
    // exist in the register and be steered back to TITLE.
    logic [3:0]         r_state;
    logic               r_fsync1;
    logic               r_fsync2;
    logic               r_fsync3;
    logic               r_hit_prev;
    logic [7:0]         r_frame_cnt;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_title_vis;
    logic [3:0]         r_fade_level;
    logic               r_battle_start;

    logic               w_tick;
    logic               w_hit;
    logic               w_confirm;
    logic [3:0]         w_state_next;
    logic [7:0]         w_cnt_next;
    logic [BLINK_W-1:0] w_blink_next;
    logic               w_vis_next;
    logic [3:0]         w_fade_next;
    logic               w_bs_next;

    // One pulse per frame_clk rising edge, after a two-flop synchroniser.
    assign w_tick    = r_fsync2 & ~r_fsync3;
    // Confirm fires on the first cycle either accept key is seen; moving
    // directly between the two keys keeps w_hit high and gives no new edge.
    assign w_hit     = (keycode == ENTER_CODE) || (keycode == CONFIRM_CODE);
    assign w_confirm = w_hit & ~r_hit_prev;

    // Synchronise frame_clk into the Clk domain and keep the key history.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_fsync1   <= 1'b0;
            r_fsync2   <= 1'b0;
            r_fsync3   <= 1'b0;
            r_hit_prev <= 1'b0;
        end else begin
            r_fsync1   <= frame_clk;
            r_fsync2   <= r_fsync1;
            r_fsync3   <= r_fsync2;
            r_hit_prev <= w_hit;
        end
    end

    // Next-state, counter and output decode for the screen sequencer.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_frame_cnt;
        w_blink_next = r_blink_cnt;
        w_vis_next   = 1'b1;
        w_bs_next    = 1'b0;
        w_fade_next  = 4'd0;

        case (r_state)
            ST_TITLE: begin
                w_vis_next = r_title_vis;
                if (w_confirm) begin
                    // Leaving wins over a coincident blink tick.
                    w_state_next = ST_FADE;
                end else if (w_tick) begin
                    if (int'(r_blink_cnt) == BLINK_FRAMES - 1) begin
                        w_vis_next   = ~r_title_vis;
                        w_blink_next = '0;
                    end else begin
                        w_blink_next = r_blink_cnt + BLINK_W'(1);
                    end
                end else begin
                    w_blink_next = r_blink_cnt;
                end
            end
            ST_FADE: begin
                if (w_tick) begin
                    if (r_frame_cnt == 8'd31) begin
                        w_state_next = ST_BATTLE;
                        w_bs_next    = 1'b1;
                    end else begin
                        w_cnt_next = r_frame_cnt + 8'd1;
                    end
                end else begin
                    w_cnt_next = r_frame_cnt;
                end
            end
            ST_BATTLE: begin
                if (player_dead) begin
                    w_state_next = ST_GAMEOVER;
                end else if (battle_won) begin
                    w_state_next = ST_WIN;
                end else begin
                    w_state_next = ST_BATTLE;
                end
            end
            ST_GAMEOVER: begin
                // Presses during the lockout are simply dropped.
                if (w_confirm && (int'(r_frame_cnt) >= GAMEOVER_FRAMES)) begin
                    w_state_next = ST_TITLE;
                end else if (w_tick && (r_frame_cnt != 8'hFF)) begin
                    w_cnt_next = r_frame_cnt + 8'd1;
                end else begin
                    w_cnt_next = r_frame_cnt;
                end
            end
            ST_WIN: begin
                if (w_confirm) begin
                    w_state_next = ST_TITLE;
                end else begin
                    w_state_next = ST_WIN;
                end
            end
            default: begin
                w_state_next = ST_TITLE;
            end
        endcase

        // Any screen change restarts the frame count and the blink phase,
        // which also makes every entry to TITLE start with the text shown.
        if (w_state_next != r_state) begin
            w_cnt_next   = 8'd0;
            w_blink_next = '0;
            w_vis_next   = 1'b1;
        end else begin
            w_cnt_next   = w_cnt_next;
        end

        if (w_state_next == ST_FADE) begin
            w_fade_next = w_cnt_next[4:1];
        end else begin
            w_fade_next = 4'd0;
        end
    end

    // Register the state, counters and every output.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state        <= ST_TITLE;
            r_frame_cnt    <= 8'd0;
            r_blink_cnt    <= '0;
            r_title_vis    <= 1'b1;
            r_fade_level   <= 4'd0;
            r_battle_start <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_frame_cnt    <= w_cnt_next;
            r_blink_cnt    <= w_blink_next;
            r_title_vis    <= w_vis_next;
            r_fade_level   <= w_fade_next;
            r_battle_start <= w_bs_next;
        end
    end

    assign status        = r_state;
    assign title_visible = r_title_vis;
    assign fade_level    = r_fade_level;
    assign battle_start  = r_battle_start;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Testbench for game_state_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural screen model.
module tb_game_state_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       player_dead = 1'b0;
    logic       battle_won = 1'b0;
    logic [3:0] status;
    logic       title_visible;
    logic [3:0] fade_level;
    logic       battle_start;

    game_state_ctrl dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .keycode       (keycode),
        .player_dead   (player_dead),
        .battle_won    (battle_won),
        .status        (status),
        .title_visible (title_visible),
        .fade_level    (fade_level),
        .battle_start  (battle_start)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    int m_scr    = 1;
    int m_vis    = 1;
    int m_fade   = 0;
    int m_bs     = 0;
    int m_frames = 0;
    int m_blink  = 0;
    int m_hitp   = 0;
    int fc_seen[3] = '{0, 0, 0};  // frame_clk as seen 1, 2 and 3 edges ago
    int inj_req  = 0;
    int inj_seen = 0;

    // Monitors.
    int fade_entries = 0;
    int bs_pulses    = 0;
    int max_fade     = 0;
    int vis_toggles  = 0;
    int prev_status  = 1;
    int prev_vis     = 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Screen model: follows the screen rules one Clk at a time.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_scr = 1; m_vis = 1; m_fade = 0; m_bs = 0;
            m_frames = 0; m_blink = 0; m_hitp = 0;
            fc_seen = '{0, 0, 0};
        end else begin
            int  nxt;
            bit  tick, hit, conf;
            if (inj_req != inj_seen) begin
                m_scr = 9;
                inj_seen = inj_req;
            end
            // A frame_clk rise is noticed once it has crossed two stages.
            tick = (fc_seen[1] == 1) && (fc_seen[2] == 0);
            fc_seen[2] = fc_seen[1];
            fc_seen[1] = fc_seen[0];
            fc_seen[0] = int'(frame_clk);
            hit  = (keycode == 8'h28) || (keycode == 8'h1D);
            conf = hit && (m_hitp == 0);
            m_hitp = hit ? 1 : 0;
            nxt  = m_scr;
            m_bs = 0;
            case (m_scr)
                1: begin
                    if (conf) nxt = 2;
                    else if (tick) begin
                        m_blink++;
                        if (m_blink == 30) begin
                            m_vis = 1 - m_vis;
                            m_blink = 0;
                        end
                    end
                end
                2: if (tick) begin
                    if (m_frames == 31) begin nxt = 3; m_bs = 1; end
                    else m_frames++;
                end
                3: begin
                    if (player_dead) nxt = 4;
                    else if (battle_won) nxt = 5;
                end
                4: begin
                    if (conf && m_frames >= 120) nxt = 1;
                    else if (tick && m_frames < 255) m_frames++;
                end
                5: if (conf) nxt = 1;
                default: nxt = 1;
            endcase
            if (nxt != m_scr) begin
                m_frames = 0; m_blink = 0; m_vis = 1;
            end
            m_scr  = nxt;
            m_fade = (m_scr == 2) ? (m_frames / 2) : 0;
        end
    end

    task automatic cyc(input int noise);
        @(negedge Clk);
        if (noise > 0 && $urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
                0: keycode = 8'h00;
                1: keycode = 8'h28;
                2: keycode = 8'h1D;
                default: keycode = 8'h04;
            endcase
        end
        if (noise > 1) begin
            player_dead = ($urandom_range(0, 7) == 0);
            battle_won  = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic frames(input int n, input int noise);
        for (int i = 0; i < n; i++) begin
            frame_clk = 1'b1;
            repeat ($urandom_range(1, 3)) cyc(noise);
            frame_clk = 1'b0;
            repeat ($urandom_range(1, 4)) cyc(noise);
        end
        if (noise > 0) begin
            @(negedge Clk);
            keycode = 8'h00; player_dead = 1'b0; battle_won = 1'b0;
        end
    endtask

    // Press a key for one cycle, check the status right after, then release.
    task automatic press(input logic [7:0] code, input string name, input int exp);
        @(negedge Clk);
        keycode = code;
        @(posedge Clk); #2;
        check(name, status, exp);
        @(negedge Clk);
        keycode = 8'h00;
        cyc(0);
    endtask

    initial begin
        // Per-cycle comparison against the model, plus event monitors.
        fork
            forever begin
                @(posedge Clk); #1;
                check("status", status, m_scr);
                check("title_visible", title_visible, m_vis);
                check("fade_level", fade_level, m_fade);
                check("battle_start", battle_start, m_bs);
                if (status == 4'd2 && prev_status != 2) fade_entries++;
                if (battle_start) bs_pulses++;
                if (fade_level > max_fade) max_fade = fade_level;
                if (title_visible != prev_vis) vis_toggles++;
                prev_status = status;
                prev_vis    = title_visible;
            end
        join_none

        // Power-up reset.
        #1 Reset = 1'b1;
        #1;
        check("reset_status", status, 1);
        check("reset_visible", title_visible, 1);
        check("reset_fade", fade_level, 0);
        check("reset_bstart", battle_start, 0);
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (3) cyc(0);

        // Start and fade: Enter held over ten frames gives one entry to FADE.
        fade_entries = 0; bs_pulses = 0; max_fade = 0;
        @(negedge Clk);
        keycode = 8'h28;
        @(posedge Clk); #2;
        check("enter_to_fade", status, 2);
        frames(10, 0);
        @(negedge Clk);
        keycode = 8'h00;
        frames(25, 0);
        repeat (6) cyc(0);
        check("fade_to_battle", status, 3);
        check("fade_entries", fade_entries, 1);
        check("bstart_pulses", bs_pulses, 1);
        check("max_fade", max_fade, 15);

        // Reset mid-BATTLE returns to TITLE at once, then blink for 65 ticks.
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("async_reset_status", status, 1);
        check("async_reset_bstart", battle_start, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        vis_toggles = 0;
        frames(65, 0);
        repeat (6) cyc(0);
        check("blink_toggles", vis_toggles, 2);
        check("blink_visible", title_visible, 1);

        // Into BATTLE with noise during FADE, then both outcome flags at once.
        press(8'h28, "enter_to_fade2", 2);
        frames(20, 2);
        frames(14, 1);
        repeat (6) cyc(0);
        check("battle_reached", status, 3);
        @(negedge Clk);
        player_dead = 1'b1; battle_won = 1'b1;
        @(posedge Clk); #2;
        check("dead_priority", status, 4);
        @(negedge Clk);
        player_dead = 1'b0; battle_won = 1'b0;

        // Game-over lockout and key edge rules.
        frames(50, 2);
        @(negedge Clk);
        keycode = 8'h1D;
        @(posedge Clk); #2;
        check("early_press", status, 4);
        @(negedge Clk);
        keycode = 8'h28;
        frames(75, 0);
        repeat (6) cyc(0);
        check("held_enter", status, 4);
        @(negedge Clk);
        keycode = 8'h1D;
        repeat (3) cyc(0);
        check("switch_no_confirm", status, 4);
        keycode = 8'h00;
        repeat (2) cyc(0);
        press(8'h1D, "late_press", 1);
        check("late_press_visible", title_visible, 1);

        // Win path.
        press(8'h28, "enter_to_fade3", 2);
        frames(34, 1);
        repeat (6) cyc(0);
        check("battle_reached2", status, 3);
        @(negedge Clk);
        battle_won = 1'b1;
        @(posedge Clk); #2;
        check("won_to_win", status, 5);
        @(negedge Clk);
        battle_won = 1'b0;
        press(8'h1D, "win_to_title", 1);

        // Illegal encoding recovers to TITLE on the next edge.
        @(negedge Clk);
        force dut.r_state = 4'd9;
        inj_req++;
        #1 release dut.r_state;
        @(posedge Clk); #2;
        check("illegal_recover", status, 1);
        check("illegal_visible", title_visible, 1);

        // Randomized traffic.
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: frames($urandom_range(1, 8), $urandom_range(0, 2));
                4: begin
                    @(negedge Clk);
                    case ($urandom_range(0, 2))
                        0: keycode = 8'h28;
                        1: keycode = 8'h1D;
                        default: keycode = 8'h04;
                    endcase
                    repeat ($urandom_range(1, 5)) cyc(0);
                    keycode = 8'h00;
                end
                5: begin
                    @(negedge Clk);
                    player_dead = ($urandom_range(0, 1) == 1);
                    battle_won  = ($urandom_range(0, 1) == 1);
                    repeat ($urandom_range(1, 3)) cyc(0);
                    player_dead = 1'b0; battle_won = 1'b0;
                end
                6: begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(negedge Clk);
                        Reset = 1'b1;
                        repeat ($urandom_range(1, 2)) @(negedge Clk);
                        Reset = 1'b0;
                    end else begin
                        cyc(0);
                    end
                end
                default: repeat ($urandom_range(1, 6)) cyc(0);
            endcase
        end
        repeat (4) cyc(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
